// File: rtl/tone_scheduler.sv
// Shares one tone divider between debounced live keys and a 16-step demo melody.
// Live keys preempt the demo, which pauses and later resumes where it stopped.
module tone_scheduler #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int BEAT_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  key,
    input  logic        demo_en,
    output logic [17:0] div_val,
    output logic        div_load,
    output logic        tone_on,
    output logic [1:0]  src,
    output logic [3:0]  step
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LIVE = 2'b01,
        DEMO = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      key_q, key_stb;
    logic [DW-1:0]   deb_cnt;
    logic [3:0]      step_q, step_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [3:0]      rom_ent;
    logic [17:0]     div_d;
    logic            tone_d;
    logic            load_d;

    function automatic logic [17:0] note_hp(input logic [2:0] n);
        case (n)
            3'd0:    note_hp = 18'd191113;
            3'd1:    note_hp = 18'd170265;
            3'd2:    note_hp = 18'd151685;
            3'd3:    note_hp = 18'd143172;
            3'd4:    note_hp = 18'd127551;
            3'd5:    note_hp = 18'd113636;
            3'd6:    note_hp = 18'd101239;
            default: note_hp = 18'd95557;
        endcase
    endfunction

    // bit3 marks a rest, bits 2:0 select the note
    function automatic logic [3:0] demo_rom(input logic [3:0] s);
        case (s)
            4'd0, 4'd3, 4'd4, 4'd7: demo_rom = 4'd0;
            4'd1, 4'd5:             demo_rom = 4'd1;
            4'd2, 4'd6, 4'd8, 4'd12: demo_rom = 4'd2;
            4'd9, 4'd13:            demo_rom = 4'd3;
            4'd10, 4'd14:           demo_rom = 4'd4;
            default:                demo_rom = 4'b1000;
        endcase
    endfunction

    function automatic logic [2:0] winner(input logic [7:0] k);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (k[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Debounce: key_stb follows key_q only after it has held steady for DEB_CYCLES
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= 8'd0;
            key_stb <= 8'd0;
            deb_cnt <= '0;
        end else begin
            key_q <= key;
            if (key != key_q) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                key_stb <= key_q;
            end else begin
                deb_cnt <= DW'(deb_cnt + 1'b1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (key_stb != 8'd0) begin
                    state_d = LIVE;
                end else if (demo_en) begin
                    state_d = DEMO;
                    step_d  = 4'd0;
                    beat_d  = '0;
                end
            end
            LIVE: begin
                // paused position is discarded once the demo is switched off
                if (!demo_en) begin
                    step_d = 4'd0;
                    beat_d = '0;
                end
                if (key_stb == 8'd0) state_d = demo_en ? DEMO : IDLE;
            end
            DEMO: begin
                if (key_stb != 8'd0) begin
                    state_d = LIVE;
                end else if (!demo_en) begin
                    state_d = IDLE;
                    step_d  = 4'd0;
                    beat_d  = '0;
                end else if (beat_q == BW'(BEAT_CYCLES - 1)) begin
                    beat_d = '0;
                    step_d = step_q + 4'd1;
                end else begin
                    beat_d = BW'(beat_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they land together with it
    always_comb begin
        rom_ent = demo_rom(step_d);
        tone_d  = 1'b0;
        div_d   = div_val;
        case (state_d)
            LIVE: begin
                tone_d = 1'b1;
                div_d  = note_hp(winner(key_stb));
            end
            DEMO: begin
                tone_d = ~rom_ent[3];
                if (!rom_ent[3]) div_d = note_hp(rom_ent[2:0]);
            end
            default: ;
        endcase
        load_d = (div_d != div_val) || (tone_d && !tone_on);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= 4'd0;
            beat_q   <= '0;
            div_val  <= 18'd0;
            tone_on  <= 1'b0;
            div_load <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            beat_q   <= beat_d;
            div_val  <= div_d;
            tone_on  <= tone_d;
            div_load <= load_d;
        end
    end

    assign src  = state_q;
    assign step = step_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler with short debounce (4) and beat (10) periods.
module tb_tone_scheduler;

    logic        clk;
    logic        rst;
    logic [7:0]  key;
    logic        demo_en;
    logic [17:0] div_val;
    logic        div_load;
    logic        tone_on;
    logic [1:0]  src;
    logic [3:0]  step;

    int n_checks = 0;
    int n_fail   = 0;
    int loads    = 0;

    tone_scheduler #(.DEB_CYCLES(4), .BEAT_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .key(key), .demo_en(demo_en),
        .div_val(div_val), .div_load(div_load), .tone_on(tone_on),
        .src(src), .step(step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // advance one edge, settle, and count load pulses seen
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (div_load === 1'b1) loads++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; key = 8'd0; demo_en = 1'b0;
        tick(3);
        n_checks++; if (div_val !== 18'd0) begin n_fail++; $display("FAIL reset_div_val: got %0d required 0", div_val); end
        n_checks++; if (div_load !== 1'b0) begin n_fail++; $display("FAIL reset_div_load: got %0b required 0", div_load); end
        n_checks++; if (tone_on !== 1'b0) begin n_fail++; $display("FAIL reset_tone_on: got %0b required 0", tone_on); end
        n_checks++; if (src !== 2'b00) begin n_fail++; $display("FAIL reset_src: got %0b required 00", src); end
        n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL reset_step: got %0d required 0", step); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single_key;
        key = 8'h04;
        loads = 0;
        tick(4);
        n_checks++; if (dut.key_stb !== 8'h00) begin n_fail++; $display("FAIL deb_early: got %h required 00", dut.key_stb); end
        tick(1);
        n_checks++; if (dut.key_stb !== 8'h04) begin n_fail++; $display("FAIL deb_accept: got %h required 04", dut.key_stb); end
        n_checks++; if (src !== 2'b00) begin n_fail++; $display("FAIL src_lag: got %0b required 00", src); end
        tick(1);
        n_checks++; if (src !== 2'b01) begin n_fail++; $display("FAIL live_src: got %0b required 01", src); end
        n_checks++; if (tone_on !== 1'b1) begin n_fail++; $display("FAIL live_tone_on: got %0b required 1", tone_on); end
        n_checks++; if (div_val !== 18'd151685) begin n_fail++; $display("FAIL live_div_val: got %0d required 151685", div_val); end
        n_checks++; if (div_load !== 1'b1) begin n_fail++; $display("FAIL live_div_load: got %0b required 1", div_load); end
        tick(1);
        n_checks++; if (div_load !== 1'b0) begin n_fail++; $display("FAIL load_one_cycle: got %0b required 0", div_load); end
        // 2-cycle glitch on bit 5
        loads = 0;
        key = 8'h24;
        tick(2);
        key = 8'h04;
        tick(10);
        n_checks++; if (dut.key_stb !== 8'h04) begin n_fail++; $display("FAIL glitch_stb: got %h required 04", dut.key_stb); end
        n_checks++; if (div_val !== 18'd151685) begin n_fail++; $display("FAIL glitch_div_val: got %0d required 151685", div_val); end
        n_checks++; if (loads !== 0) begin n_fail++; $display("FAIL glitch_loads: got %0d required 0", loads); end
    endtask

    task automatic test_priority;
        loads = 0;
        key = 8'h24;
        tick(7);
        n_checks++; if (dut.key_stb !== 8'h24) begin n_fail++; $display("FAIL prio_stb: got %h required 24", dut.key_stb); end
        n_checks++; if (div_val !== 18'd151685) begin n_fail++; $display("FAIL prio_low_wins: got %0d required 151685", div_val); end
        n_checks++; if (loads !== 0) begin n_fail++; $display("FAIL prio_no_load: got %0d required 0", loads); end
        key = 8'h20;
        tick(5);
        n_checks++; if (div_val !== 18'd151685) begin n_fail++; $display("FAIL prio_hold: got %0d required 151685", div_val); end
        tick(1);
        n_checks++; if (div_val !== 18'd113636) begin n_fail++; $display("FAIL prio_release: got %0d required 113636", div_val); end
        n_checks++; if (loads !== 1) begin n_fail++; $display("FAIL prio_loads: got %0d required 1", loads); end
        key = 8'h00;
        tick(6);
        n_checks++; if (src !== 2'b00) begin n_fail++; $display("FAIL idle_src: got %0b required 00", src); end
        n_checks++; if (tone_on !== 1'b0) begin n_fail++; $display("FAIL idle_tone_on: got %0b required 0", tone_on); end
        n_checks++; if (div_val !== 18'd113636) begin n_fail++; $display("FAIL idle_div_hold: got %0d required 113636", div_val); end
    endtask

    task automatic test_demo_and_preempt;
        demo_en = 1'b1;
        tick(1);
        // this edge is the demo origin E0: step 0, beat 0
        n_checks++; if (src !== 2'b10) begin n_fail++; $display("FAIL demo_src: got %0b required 10", src); end
        n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL demo_step0: got %0d required 0", step); end
        n_checks++; if (div_val !== 18'd191113) begin n_fail++; $display("FAIL demo_div0: got %0d required 191113", div_val); end
        n_checks++; if (div_load !== 1'b1) begin n_fail++; $display("FAIL demo_load0: got %0b required 1", div_load); end
        loads = 0;
        tick(40);
        n_checks++; if (step !== 4'd4) begin n_fail++; $display("FAIL demo_step4: got %0d required 4", step); end
        n_checks++; if (div_val !== 18'd191113) begin n_fail++; $display("FAIL demo_div4: got %0d required 191113", div_val); end
        n_checks++; if (loads !== 3) begin n_fail++; $display("FAIL demo_loads_equal_notes: got %0d required 3", loads); end
        tick(70);
        n_checks++; if (step !== 4'd11) begin n_fail++; $display("FAIL demo_step11: got %0d required 11", step); end
        n_checks++; if (tone_on !== 1'b0) begin n_fail++; $display("FAIL demo_rest: got %0b required 0", tone_on); end
        n_checks++; if (div_val !== 18'd127551) begin n_fail++; $display("FAIL demo_rest_hold: got %0d required 127551", div_val); end
        tick(10);
        n_checks++; if (tone_on !== 1'b1 || div_load !== 1'b1) begin n_fail++; $display("FAIL rest_to_note: got tone_on=%0b load=%0b required 1 1", tone_on, div_load); end
        tick(40);
        n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL demo_wrap: got %0d required 0", step); end
        n_checks++; if (div_val !== 18'd191113) begin n_fail++; $display("FAIL demo_wrap_div: got %0d required 191113", div_val); end
        // E0+160; key press lands in key_stb at step 2 beat 6 (E0+186)
        tick(21);
        key = 8'h80;
        tick(6);
        n_checks++; if (src !== 2'b01) begin n_fail++; $display("FAIL preempt_src: got %0b required 01", src); end
        n_checks++; if (div_val !== 18'd95557) begin n_fail++; $display("FAIL preempt_div: got %0d required 95557", div_val); end
        n_checks++; if (step !== 4'd2) begin n_fail++; $display("FAIL preempt_step: got %0d required 2", step); end
        tick(3);
        key = 8'h00;
        tick(6);
        n_checks++; if (src !== 2'b10) begin n_fail++; $display("FAIL resume_src: got %0b required 10", src); end
        n_checks++; if (step !== 4'd2) begin n_fail++; $display("FAIL resume_step: got %0d required 2", step); end
        n_checks++; if (dut.beat_q !== 6) begin n_fail++; $display("FAIL resume_beat: got %0d required 6", dut.beat_q); end
        n_checks++; if (div_val !== 18'd151685) begin n_fail++; $display("FAIL resume_div: got %0d required 151685", div_val); end
        tick(3);
        n_checks++; if (step !== 4'd2) begin n_fail++; $display("FAIL resume_remaining: got %0d required 2", step); end
        tick(1);
        n_checks++; if (step !== 4'd3 || div_val !== 18'd191113) begin n_fail++; $display("FAIL resume_advance: got step=%0d div=%0d required 3 191113", step, div_val); end
    endtask

    task automatic test_mid_events;
        demo_en = 1'b0;
        tick(1);
        n_checks++; if (src !== 2'b00) begin n_fail++; $display("FAIL drop_src: got %0b required 00", src); end
        n_checks++; if (tone_on !== 1'b0) begin n_fail++; $display("FAIL drop_tone_on: got %0b required 0", tone_on); end
        n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL drop_step: got %0d required 0", step); end
        key = 8'h01;
        tick(6);
        n_checks++; if (src !== 2'b01 || tone_on !== 1'b1) begin n_fail++; $display("FAIL live_again: got src=%0b tone_on=%0b required 01 1", src, tone_on); end
        rst = 1'b1;
        tick(1);
        n_checks++; if (src !== 2'b00 || tone_on !== 1'b0 || div_load !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got src=%0b tone_on=%0b load=%0b required 00 0 0", src, tone_on, div_load); end
        n_checks++; if (div_val !== 18'd0 || step !== 4'd0) begin n_fail++; $display("FAIL midrst_data: got div=%0d step=%0d required 0 0", div_val, step); end
        n_checks++; if (dut.key_stb !== 8'h00 || dut.key_q !== 8'h00) begin n_fail++; $display("FAIL midrst_keys: got stb=%h q=%h required 00 00", dut.key_stb, dut.key_q); end
        rst = 1'b0;
        key = 8'h00;
        tick(2);
    endtask

    initial begin
        rst = 1'b1; key = 8'd0; demo_en = 1'b0;
        test_reset;
        test_single_key;
        test_priority;
        test_demo_and_preempt;
        test_mid_events;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
